// File: rtl/alu_wb_sequencer.sv
// alu_wb_sequencer: multicycle IDLE->READ->EXEC->WB controller that feeds a
// 4x4 register file. Accepts one instruction over valid/ready, reads operands
// from r0..r3, computes a result and issues a one-cycle one-hot write enable.
// Ports: clk, reset (sync, active-high); instr_valid/instr_ready handshake;
// opcode, rdest, rsrc, imm instruction fields; r0..r3 register-file contents;
// alu_bus write data; reg_enable one-hot write strobe; busy; flags {C,Z}.
// Optional feature macro: ALU_FLAGS_EN (flags register; tied to 00 otherwise).
module alu_wb_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [2:0]       opcode,
   input  logic [1:0]       rdest,
   input  logic [1:0]       rsrc,
   input  logic [WIDTH-1:0] imm,
   input  logic [WIDTH-1:0] r0,
   input  logic [WIDTH-1:0] r1,
   input  logic [WIDTH-1:0] r2,
   input  logic [WIDTH-1:0] r3,
   output logic [WIDTH-1:0] alu_bus,
   output logic [3:0]       reg_enable,
   output logic             busy,
   output logic [1:0]       flags
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_EXEC,
      ST_WB
   } state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_MOV = 3'b101;
   localparam logic [2:0] OP_LDI = 3'b110;
   localparam logic [2:0] OP_NOP = 3'b111;

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [1:0]       rdest_q, rdest_d;
   logic [1:0]       rsrc_q, rsrc_d;
   logic [WIDTH-1:0] imm_q, imm_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] bus_q, bus_d;
   logic [3:0]       en_q, en_d;
   logic [WIDTH-1:0] rd_val, rs_val, res;

   assign instr_ready = (state_q == ST_IDLE);
   assign busy        = (state_q != ST_IDLE);
   assign alu_bus     = bus_q;
   assign reg_enable  = en_q;

   always_comb begin
      rd_val = r0;
      unique case (rdest_q)
         2'd0: rd_val = r0;
         2'd1: rd_val = r1;
         2'd2: rd_val = r2;
         2'd3: rd_val = r3;
      endcase
      rs_val = r0;
      unique case (rsrc_q)
         2'd0: rs_val = r0;
         2'd1: rs_val = r1;
         2'd2: rs_val = r2;
         2'd3: rs_val = r3;
      endcase
   end

   // NOP recirculates the bus so the held value is never disturbed.
   always_comb begin
      res = bus_q;
      unique case (op_q)
         OP_ADD: res = a_q + b_q;
         OP_SUB: res = a_q - b_q;
         OP_AND: res = a_q & b_q;
         OP_OR:  res = a_q | b_q;
         OP_XOR: res = a_q ^ b_q;
         OP_MOV: res = b_q;
         OP_LDI: res = imm_q;
         OP_NOP: res = bus_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      rdest_d = rdest_q;
      rsrc_d  = rsrc_q;
      imm_d   = imm_q;
      a_d     = a_q;
      b_d     = b_q;
      bus_d   = bus_q;
      en_d    = 4'b0000;
      unique case (state_q)
         ST_IDLE: begin
            if (instr_valid) begin
               op_d    = opcode;
               rdest_d = rdest;
               rsrc_d  = rsrc;
               imm_d   = imm;
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            a_d     = rd_val;
            b_d     = rs_val;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            // Strobe is registered here so it is high for the WB cycle only.
            if (op_q != OP_NOP) begin
               bus_d = res;
               en_d  = 4'b0001 << rdest_q;
            end
            state_d = ST_WB;
         end
         ST_WB: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         rdest_q <= '0;
         rsrc_q  <= '0;
         imm_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         bus_q   <= '0;
         en_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rdest_q <= rdest_d;
         rsrc_q  <= rsrc_d;
         imm_q   <= imm_d;
         a_q     <= a_d;
         b_q     <= b_d;
         bus_q   <= bus_d;
         en_q    <= en_d;
      end
   end

`ifdef ALU_FLAGS_EN
   logic [1:0] flags_q, flags_d;
   logic       carry, borrow, zero;

   // An add overflowed iff the wrapped sum is below an operand.
   assign carry  = (res < a_q);
   assign borrow = (a_q < b_q);
   assign zero   = (res == '0);

   always_comb begin
      flags_d = flags_q;
      if (state_q == ST_EXEC) begin
         unique case (op_q)
            OP_ADD: flags_d = {carry, zero};
            OP_SUB: flags_d = {borrow, zero};
            OP_AND,
            OP_OR,
            OP_XOR: flags_d = {1'b0, zero};
            default: flags_d = flags_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) flags_q <= 2'b00;
      else       flags_q <= flags_d;
   end

   assign flags = flags_q;
`else
   assign flags = 2'b00;
`endif

endmodule
